// File: rtl/buffer_pkg.sv
// Shared constants and mod-DEPTH helpers for the buffer pointer controller.
package buffer_pkg;

  localparam string ORDER_FIFO = "FIFO";
  localparam string ORDER_LIFO = "LIFO";

  function automatic int unsigned wrap_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr >= depth - 1) ? 32'd0 : ptr + 1;
  endfunction

  function automatic int unsigned wrap_dec(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

  // Occupancy needs one bit more than an address to represent DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Mod-DEPTH up/down counter used as a buffer pointer.
module wrap_counter
  import buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] count
);

  logic [AW-1:0] count_q;
  logic [AW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      count_d = AW'(wrap_inc(32'(count_q), DEPTH));
    end else if (dec && !inc) begin
      count_d = AW'(wrap_dec(32'(count_q), DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/buffer_pointer_ctrl.sv
// Pointer, occupancy and status control for a FIFO/LIFO buffer
// in front of a read-first synchronous RAM.
module buffer_pointer_ctrl
  import buffer_pkg::*;
#(
  parameter int    DEPTH         = 8,
  parameter string POP_ORDER     = "FIFO",
  parameter int    AFULL_THRESH  = DEPTH - 1,
  parameter int    AEMPTY_THRESH = 1,
  localparam int   ADDR_W        = $clog2(DEPTH),
  localparam int   CW            = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              clr_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam bit IS_LIFO = (POP_ORDER == ORDER_LIFO);

  if (POP_ORDER != ORDER_FIFO && POP_ORDER != ORDER_LIFO) begin : g_bad_order
    $fatal(1, "buffer_pointer_ctrl: POP_ORDER must be FIFO or LIFO");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "buffer_pointer_ctrl: DEPTH must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_acc, pop_acc;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == CW'(DEPTH));
  assign almost_full  = (32'(cnt_q) >= 32'(AFULL_THRESH));
  assign almost_empty = (32'(cnt_q) <= 32'(AEMPTY_THRESH));

  // A full buffer can still take a push when a pop frees the slot.
  assign pop_acc  = pop && !empty && !flush;
  assign push_acc = push && !flush && (!full || pop_acc);
  assign wr_en    = push_acc;
  assign rd_en    = pop_acc;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (push_acc && !pop_acc) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_acc && !push_acc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign ovf_d = (ovf_q && !clr_err) || (push && !push_acc && !flush);
  assign unf_d = (unf_q && !clr_err) || (pop && !pop_acc && !flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  if (IS_LIFO) begin : g_lifo
    logic [ADDR_W-1:0] sp_top;
    logic [ADDR_W-1:0] sp_m1;
    // Stack pointer is the occupancy; clamp so idle addresses stay in range.
    assign sp_top  = full ? ADDR_W'(DEPTH - 1) : ADDR_W'(cnt_q);
    assign sp_m1   = empty ? '0 : ADDR_W'(cnt_q - CW'(1));
    assign wr_addr = (push_acc && pop_acc) ? sp_m1 : sp_top;
    assign rd_addr = sp_m1;
  end else begin : g_fifo
    wrap_counter #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .inc   (push_acc),
      .dec   (1'b0),
      .count (wr_addr)
    );
    wrap_counter #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .inc   (pop_acc),
      .dec   (1'b0),
      .count (rd_addr)
    );
  end

  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_buffer_pointer_ctrl.sv
// Directed bench: FIFO depth 8, FIFO depth 5 and LIFO depth 8 instances.
module tb_buffer_pointer_ctrl;

  logic       clk = 1'b0;
  logic [2:0] rst, push, pop, flush, clr_err;
  logic [2:0] wr_en, rd_en, full, empty, af, ae, ovf, unf;
  logic [2:0] wr_addr [3];
  logic [2:0] rd_addr [3];
  logic [3:0] count [3];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  buffer_pointer_ctrl #(.DEPTH(8), .POP_ORDER("FIFO")) u_f8 (
    .clk(clk), .rst(rst[0]), .push(push[0]), .pop(pop[0]),
    .flush(flush[0]), .clr_err(clr_err[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .count(count[0]),
    .full(full[0]), .empty(empty[0]),
    .almost_full(af[0]), .almost_empty(ae[0]),
    .overflow(ovf[0]), .underflow(unf[0])
  );

  buffer_pointer_ctrl #(.DEPTH(5), .POP_ORDER("FIFO")) u_f5 (
    .clk(clk), .rst(rst[1]), .push(push[1]), .pop(pop[1]),
    .flush(flush[1]), .clr_err(clr_err[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .count(count[1]),
    .full(full[1]), .empty(empty[1]),
    .almost_full(af[1]), .almost_empty(ae[1]),
    .overflow(ovf[1]), .underflow(unf[1])
  );

  buffer_pointer_ctrl #(.DEPTH(8), .POP_ORDER("LIFO")) u_l8 (
    .clk(clk), .rst(rst[2]), .push(push[2]), .pop(pop[2]),
    .flush(flush[2]), .clr_err(clr_err[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .count(count[2]),
    .full(full[2]), .empty(empty[2]),
    .almost_full(af[2]), .almost_empty(ae[2]),
    .overflow(ovf[2]), .underflow(unf[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    push[k] = 0; pop[k] = 0; flush[k] = 0; clr_err[k] = 0; rst[k] = 0;
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk({tag, " count"}, count[k], 0);
    chk({tag, " empty"}, empty[k], 1);
    chk({tag, " full"}, full[k], 0);
    chk({tag, " aempty"}, ae[k], 1);
    chk({tag, " afull"}, af[k], 0);
    chk({tag, " ovf"}, ovf[k], 0);
    chk({tag, " unf"}, unf[k], 0);
  endtask

  initial begin
    rst = '1; push = '0; pop = '0; flush = '0; clr_err = '0;
    tick();
    tick();
    rst = '0;
    for (int k = 0; k < 3; k++) chk_reset(k, "reset");

    // FIFO8: fill, then one push too many
    for (int i = 0; i < 8; i++) begin
      push[0] = 1; #1;
      chk("f8 fill wr_en", wr_en[0], 1);
      chk("f8 fill wr_addr", wr_addr[0], i);
      tick();
      chk("f8 fill count", count[0], i + 1);
      chk("f8 fill afull", af[0], (i + 1 >= 7) ? 1 : 0);
    end
    chk("f8 full", full[0], 1);
    #1;
    chk("f8 9th wr_en", wr_en[0], 0);
    tick();
    chk("f8 ovf set", ovf[0], 1);
    chk("f8 count held", count[0], 8);
    idle(0); clr_err[0] = 1;
    tick();
    chk("f8 ovf clr", ovf[0], 0);

    // FIFO8 full: simultaneous push/pop
    idle(0);
    for (int i = 0; i < 3; i++) begin
      push[0] = 1; pop[0] = 1; #1;
      chk("f8 pp wr_en", wr_en[0], 1);
      chk("f8 pp rd_en", rd_en[0], 1);
      chk("f8 pp wr_addr", wr_addr[0], i);
      chk("f8 pp rd_addr", rd_addr[0], i);
      tick();
      chk("f8 pp count", count[0], 8);
      chk("f8 pp ovf", ovf[0], 0);
    end

    // FIFO8: overflow again, drop to 5, flush with push
    idle(0); push[0] = 1;
    tick();
    chk("f8 ovf2", ovf[0], 1);
    idle(0); pop[0] = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("f8 count5", count[0], 5);
    idle(0); push[0] = 1; flush[0] = 1; #1;
    chk("f8 flush wr_en", wr_en[0], 0);
    tick();
    chk("f8 flush count", count[0], 0);
    chk("f8 flush empty", empty[0], 1);
    chk("f8 flush ovf", ovf[0], 1);
    idle(0); #1;
    chk("f8 flush wr_addr", wr_addr[0], 0);
    chk("f8 flush rd_addr", rd_addr[0], 0);

    // Underflow sticky behaviour
    idle(0); pop[0] = 1; #1;
    chk("unf rd_en", rd_en[0], 0);
    tick();
    chk("unf set", unf[0], 1);
    clr_err[0] = 1;
    tick();
    chk("unf clr+err", unf[0], 1);
    idle(0); clr_err[0] = 1;
    tick();
    chk("unf clr", unf[0], 0);
    chk("ovf clr", ovf[0], 0);

    // Refill to 8, overflow, back to 5, then reset with push
    idle(0); push[0] = 1;
    for (int i = 0; i < 9; i++) tick();
    chk("f8 ovf3", ovf[0], 1);
    idle(0); pop[0] = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("f8 count5b", count[0], 5);
    idle(0); push[0] = 1; rst[0] = 1;
    tick();
    idle(0); #1;
    chk_reset(0, "f8 rst");
    chk("f8 rst wr_addr", wr_addr[0], 0);
    chk("f8 rst rd_addr", rd_addr[0], 0);

    // FIFO5: wrap on non-power-of-two depth
    push[1] = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("f5 wr_addr", wr_addr[1], i);
      tick();
    end
    chk("f5 full", full[1], 1);
    chk("f5 count", count[1], 5);
    idle(1); pop[1] = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("f5 rd_en", rd_en[1], 1);
      chk("f5 rd_addr", rd_addr[1], i);
      tick();
    end
    chk("f5 empty", empty[1], 1);
    idle(1); push[1] = 1; #1;
    chk("f5 wrap wr_addr", wr_addr[1], 0);
    chk("f5 wrap rd_addr", rd_addr[1], 0);
    tick();
    chk("f5 count1", count[1], 1);
    idle(1);

    // LIFO8
    push[2] = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("l8 push wr_addr", wr_addr[2], i);
      tick();
    end
    idle(2); pop[2] = 1; #1;
    chk("l8 pop rd_addr", rd_addr[2], 2);
    tick();
    chk("l8 pop count", count[2], 2);
    push[2] = 1; #1;
    chk("l8 rep wr_en", wr_en[2], 1);
    chk("l8 rep rd_en", rd_en[2], 1);
    chk("l8 rep wr_addr", wr_addr[2], 1);
    chk("l8 rep rd_addr", rd_addr[2], 1);
    tick();
    chk("l8 rep count", count[2], 2);
    idle(2); pop[2] = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("l8 drain rd_addr", rd_addr[2], 1 - i);
      tick();
    end
    chk("l8 empty", empty[2], 1);
    push[2] = 1; #1;
    chk("l8 pp-empty wr_en", wr_en[2], 1);
    chk("l8 pp-empty rd_en", rd_en[2], 0);
    chk("l8 pp-empty wr_addr", wr_addr[2], 0);
    tick();
    chk("l8 pp-empty count", count[2], 1);
    chk("l8 pp-empty unf", unf[2], 1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_pointer_ctrl.md
Name: buffer_pointer_ctrl

Overview:
Pointer, occupancy and status controller for a single-port-write / single-port-read buffer memory. Order is FIFO or LIFO by parameter. Supports any DEPTH ≥ 2, including non-power-of-two. Adds full/empty/almost flags, an occupancy count, sticky error flags and a flush. It sits between the push/pop client and a read-first synchronous RAM wrapper, driving that RAM's addresses and enables.

Parameters:
DEPTH, 8, number of entries; must be ≥ 2; non-power-of-two allowed.
POP_ORDER, "FIFO", "FIFO" or "LIFO"; any other value → $fatal at elaboration.
AFULL_THRESH, DEPTH-1, almost_full asserts when count ≥ this value.
AEMPTY_THRESH, 1, almost_empty asserts when count ≤ this value.
ADDR_W (localparam), $clog2(DEPTH), address width.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous reset, active-high.
push  in  1  write request.
pop  in  1  read request.
flush  in  1  synchronous empty request.
clr_err  in  1  clears the sticky error flags.
wr_en  out  1  RAM write strobe (push accepted).
wr_addr  out  ADDR_W  RAM write address.
rd_en  out  1  RAM read strobe (pop accepted).
rd_addr  out  ADDR_W  RAM read address.
count  out  ADDR_W+1  occupancy, range 0..DEPTH.
full, empty, almost_full, almost_empty  out  1 each  status flags, decoded from count.
overflow, underflow  out  1 each  sticky error flags.

Behaviour:
- Reset (rst=1 at an edge): pointers = 0, count = 0, overflow = underflow = 0. Reset overrides every other input, including mid-operation.
- Reset values of the decoded outputs: empty = 1, full = 0, almost_empty = 1, almost_full = (AFULL_THRESH == 0).
- Flags are combinational decodes of the registered count only; there is no input-to-flag path.
- wr_en, rd_en, wr_addr and rd_addr are combinational from registered state and this cycle's push/pop/flush.
- Pointers and count update on the next edge, so there is 1 cycle of state latency. Read data appears 1 cycle after rd_en and is the RAM's responsibility.
- Acceptance rules:
  - pop_acc = pop & !empty & !flush.
  - push_acc = push & !flush & (!full | pop_acc).
  - wr_en = push_acc; rd_en = pop_acc.
- FIFO mode:
  - wr_addr = wr_ptr; rd_addr = rd_ptr.
  - Each pointer increments mod DEPTH on acceptance (DEPTH-1 → 0).
  - count += push_acc − pop_acc.
  - When full with push and pop together: both are accepted, wr_addr == rd_addr, and the read-first RAM returns the old data.
- LIFO mode:
  - sp = count.
  - Push only: wr_addr = sp, count + 1.
  - Pop only: rd_addr = sp − 1, count − 1.
  - Push and pop with count > 0: replace top, rd_addr = wr_addr = sp − 1, count unchanged; this is legal even when full.
  - Push and pop when empty: the pop is rejected, the push is accepted at wr_addr = 0.
- Idle addresses when an enable is low: FIFO drives the current pointers. LIFO drives wr_addr = min(sp, DEPTH−1) and rd_addr = max(sp−1, 0).
- Errors:
  - overflow is set on push & !push_acc & !flush.
  - underflow is set on pop & !pop_acc & !flush.
  - Both flags hold until clr_err or rst. If clr_err coincides with a new error, the set wins.
  - flush does not clear the error flags.
- flush: forces wr_en = rd_en = 0 that cycle. Pointers and count go to 0 at the next edge.

Decomposition:
- Package buffer_pkg:
  - pop_order string constants "FIFO"/"LIFO".
  - function wrap_inc(ptr, depth) and function wrap_dec(ptr, depth) for mod-DEPTH arithmetic.
  - count-width helper function.
- One sub-module, wrap_counter #(DEPTH):
  - Ports: clk, rst, clr, inc, dec, count.
  - Behaviour: mod-DEPTH up/down counter; inc & dec together leave it unchanged.
  - Instantiated twice in FIFO mode (rd_ptr, wr_ptr).
  - LIFO mode uses the count register alone.

Test Plan:
1. FIFO, DEPTH=8, 8 pushes after reset → wr_addr 0..7. almost_full rises after the 7th push; full = 1 and count = 8 after the 8th. A 9th push gives wr_en = 0 and overflow = 1 on the next cycle.
2. FIFO, DEPTH=5: 5 pushes, 5 pops, then 1 push → rd_addr 0,1,2,3,4; final wr_addr = 0 (wrap); empty = 1 before the last push.
3. FIFO full (count = 8), push & pop for 3 cycles → wr_en = rd_en = 1 each cycle, wr_addr == rd_addr, count stays 8, overflow stays 0.
4. LIFO, DEPTH=8:
   - push ×3 → wr_addr 0,1,2.
   - pop → rd_addr 2, count 2.
   - push & pop → rd_addr = wr_addr = 1, count 2.
   - pop ×2 → rd_addr 1, 0; empty = 1.
5. Error flags: pop on empty → rd_en = 0, underflow = 1. clr_err with another empty pop → underflow stays 1. clr_err alone → underflow = 0.
6. Flush/reset at count = 5 with push = 1:
   - flush → wr_en = 0; next cycle count = 0, empty = 1, sticky errors unchanged.
   - Repeat with rst instead → all outputs at reset values, errors = 0.
